// File: rtl/arbiter_grant_ctrl_if.sv
// Bundle between the requester-side grant controller and its clients/arbiter.
// The slave modport is the controller's view; master is the environment's view.
interface arbiter_grant_ctrl_if;
  logic [3:0] req_pulse;
  logic [3:0] done;
  logic [2:0] gnt_id;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [2:0] owner_id;
  logic       busy;
  logic       timeout;
  logic       illegal_id;

  modport slave (
    input  req_pulse, done, gnt_id,
    output req, gnt, owner_id, busy, timeout, illegal_id
  );

  modport master (
    output req_pulse, done, gnt_id,
    input  req, gnt, owner_id, busy, timeout, illegal_id
  );
endinterface

// File: rtl/arbiter_grant_ctrl.sv
// Requester-side grant controller: sticky requests toward a fixed-priority
// arbiter, registered one-hot grant, release on owner done or hold timeout.
//
// state   | meaning
// IDLE    | no owner; sample arbiter gnt_id each cycle
// GRANT   | owner holds gnt; hold counter runs
// RELEASE | one-cycle gap; owner's pending bit already cleared
module arbiter_grant_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  arbiter_grant_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] clr_mask;
  logic [3:0] gnt_q, gnt_d;
  logic [2:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gnt_q     <= '0;
      owner_q   <= 3'd4;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    illegal_d = 1'b0;
    clr_mask  = '0;
    case (state_q)
      IDLE: begin
        if (bus.gnt_id <= 3'd3) begin
          // An arbiter naming a non-pending client is ignored silently.
          if (pending_q[bus.gnt_id[1:0]]) begin
            state_d = GRANT;
            gnt_d   = 4'(4'b0001 << bus.gnt_id[1:0]);
            owner_d = bus.gnt_id;
            cnt_d   = '0;
          end
        end else if (bus.gnt_id != 3'd4) begin
          illegal_d = 1'b1;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.done[owner_q[1:0]] || (cnt_q == CNT_W'(MAX_HOLD - 1))) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          owner_d   = 3'd4;
          cnt_d     = '0;
          clr_mask  = gnt_q;
          timeout_d = ~bus.done[owner_q[1:0]];
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = 3'd4;
        cnt_d   = '0;
      end
    endcase
  end

  // A same-edge re-request survives the release clear.
  assign pending_d = (pending_q & ~clr_mask) | bus.req_pulse;

  assign bus.req        = pending_q;
  assign bus.gnt        = gnt_q;
  assign bus.owner_id   = owner_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.timeout    = timeout_q;
  assign bus.illegal_id = illegal_q;
endmodule

// File: tb/tb_arbiter_grant_ctrl.sv
// Directed bench for arbiter_grant_ctrl with a fixed-priority arbiter model
// driving gnt_id, plus an override to inject illegal/inconsistent ids.
module tb_arbiter_grant_ctrl;
  logic clk;
  logic rst;
  logic       force_en;
  logic [2:0] force_val;
  int n_cmp;
  int n_err;

  arbiter_grant_ctrl_if bus ();

  arbiter_grant_ctrl #(.MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [2:0] arb(input logic [3:0] r);
    if (r[0]) return 3'd0;
    if (r[1]) return 3'd1;
    if (r[2]) return 3'd2;
    if (r[3]) return 3'd3;
    return 3'd4;
  endfunction

  assign bus.gnt_id = force_en ? force_val : arb(bus.req);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] r, input logic [3:0] g,
                           input logic [2:0] o, input logic b);
    chk({tag, ".req"},   8'(bus.req),      8'(r));
    chk({tag, ".gnt"},   8'(bus.gnt),      8'(g));
    chk({tag, ".owner"}, 8'(bus.owner_id), 8'(o));
    chk({tag, ".busy"},  8'(bus.busy),     8'(b));
  endtask

  // Grant to id is expected one cycle after the IDLE sample; done on the 2nd grant cycle.
  task automatic serve(input logic [1:0] id, input logic [3:0] req_before, input logic [3:0] req_after);
    logic [3:0] oh;
    oh = 4'(4'b0001 << id);
    tick();
    chk_state("serve.g1", req_before, oh, {1'b0, id}, 1'b1);
    tick();
    chk_state("serve.g2", req_before, oh, {1'b0, id}, 1'b1);
    bus.done = oh;
    tick();
    bus.done = 4'b0000;
    chk_state("serve.rel", req_after, 4'b0000, 3'd4, 1'b1);
    chk("serve.rel.timeout", 8'(bus.timeout), 8'd0);
    tick();
    chk_state("serve.idle", req_after, 4'b0000, 3'd4, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    force_en = 1'b0;
    force_val = 3'd0;
    bus.req_pulse = 4'b0000;
    bus.done = 4'b0000;
    #2;
    chk_state("reset", 4'b0000, 4'b0000, 3'd4, 1'b0);
    chk("reset.timeout", 8'(bus.timeout), 8'd0);
    chk("reset.illegal", 8'(bus.illegal_id), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk_state("idle", 4'b0000, 4'b0000, 3'd4, 1'b0);
    end

    // Single request from client 2
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = 4'b0000;
    chk_state("single.req", 4'b0100, 4'b0000, 3'd4, 1'b0);
    serve(2'd2, 4'b0100, 4'b0000);

    // Contention: clients 0, 1, 3 together
    bus.req_pulse = 4'b1011;
    tick();
    bus.req_pulse = 4'b0000;
    chk_state("cont.req", 4'b1011, 4'b0000, 3'd4, 1'b0);
    serve(2'd0, 4'b1011, 4'b1010);
    serve(2'd1, 4'b1010, 4'b1000);
    serve(2'd3, 4'b1000, 4'b0000);

    // Timeout: client 1 never signals done
    bus.req_pulse = 4'b0010;
    tick();
    bus.req_pulse = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_state("tmo.hold", 4'b0010, 4'b0010, 3'd1, 1'b1);
      chk("tmo.hold.timeout", 8'(bus.timeout), 8'd0);
    end
    tick();
    chk_state("tmo.rel", 4'b0000, 4'b0000, 3'd4, 1'b1);
    chk("tmo.pulse", 8'(bus.timeout), 8'd1);
    tick();
    chk_state("tmo.idle", 4'b0000, 4'b0000, 3'd4, 1'b0);
    chk("tmo.pulse_end", 8'(bus.timeout), 8'd0);

    // Done coinciding with expiry: no timeout pulse
    bus.req_pulse = 4'b0010;
    tick();
    bus.req_pulse = 4'b0000;
    for (int i = 0; i < 16; i++) tick();
    chk_state("tmo2.last", 4'b0010, 4'b0010, 3'd1, 1'b1);
    bus.done = 4'b0010;
    tick();
    bus.done = 4'b0000;
    chk_state("tmo2.rel", 4'b0000, 4'b0000, 3'd4, 1'b1);
    chk("tmo2.no_pulse", 8'(bus.timeout), 8'd0);
    tick();

    // Stray done from a non-owner, then owner re-requests on its done edge
    bus.req_pulse = 4'b0001;
    tick();
    bus.req_pulse = 4'b0000;
    tick();
    chk_state("rereq.g1", 4'b0001, 4'b0001, 3'd0, 1'b1);
    bus.done = 4'b1000;
    tick();
    chk_state("rereq.stray", 4'b0001, 4'b0001, 3'd0, 1'b1);
    bus.done = 4'b0001;
    bus.req_pulse = 4'b0001;
    tick();
    bus.done = 4'b0000;
    bus.req_pulse = 4'b0000;
    chk_state("rereq.rel", 4'b0001, 4'b0000, 3'd4, 1'b1);
    tick();
    chk_state("rereq.idle", 4'b0001, 4'b0000, 3'd4, 1'b0);
    serve(2'd0, 4'b0001, 4'b0000);

    // Illegal id in IDLE
    force_en = 1'b1;
    force_val = 3'd6;
    tick();
    force_en = 1'b0;
    chk("illegal.pulse", 8'(bus.illegal_id), 8'd1);
    chk_state("illegal.nogrant", 4'b0000, 4'b0000, 3'd4, 1'b0);
    tick();
    chk("illegal.end", 8'(bus.illegal_id), 8'd0);

    // Inconsistent arbiter: names client 2 that has no pending request
    force_en = 1'b1;
    force_val = 3'd2;
    tick();
    force_en = 1'b0;
    chk("incons.no_pulse", 8'(bus.illegal_id), 8'd0);
    chk_state("incons.nogrant", 4'b0000, 4'b0000, 3'd4, 1'b0);

    // Asynchronous reset during a grant
    bus.req_pulse = 4'b0100;
    tick();
    bus.req_pulse = 4'b0000;
    tick();
    chk_state("mid.g1", 4'b0100, 4'b0100, 3'd2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_state("mid.rst", 4'b0000, 4'b0000, 3'd4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_state("mid.after", 4'b0000, 4'b0000, 3'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arbiter_grant_ctrl.md
Name: arbiter_grant_ctrl

Overview:
Requester-side companion to the 4-way fixed-priority arbiter; consumes its encoded grant.
- Latches client request pulses into sticky request lines that drive the arbiter's req0..req3.
- Samples the arbiter's encoded gnt_id (0-3 = winner, 4 = none) and turns it into a registered one-hot grant.
- Holds the grant until the owning client signals done, or until a hold-timeout expires.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before forced release (legal range 2..255)
CNT_W, $clog2(MAX_HOLD+1), width of the hold counter (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_pulse  input  4  client request strobes, bit i = client i, one-cycle pulse per request
done  input  4  client transaction complete, bit i = client i; only the owner's bit is honoured
gnt_id  input  3  encoded grant from arbiter: 0-3 winner, 4 none, 5-7 illegal
req  output  4  sticky pending requests to arbiter, bit i wired to arbiter req_i
gnt  output  4  registered one-hot grant to clients
owner_id  output  3  id of current grant owner; 4 when no owner
busy  output  1  high while in GRANT or RELEASE
timeout  output  1  one-cycle pulse when a grant is forcibly released by the hold counter
illegal_id  output  1  one-cycle pulse when gnt_id in 5..7 is sampled in IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, req=0, gnt=0, owner_id=4, busy=0, timeout=0, illegal_id=0, hold counter=0. Reset mid-grant drops gnt immediately; pending requests are lost.
- Pending register, bit i:
  - set on the edge where req_pulse[i]=1;
  - cleared on entry to RELEASE when i==owner;
  - set wins over clear on the same edge, so a re-request by the owner during its grant is re-queued;
  - a pulse on an already-pending bit has no effect;
  - req = pending (registered, no combinational path from req_pulse).
- gnt_id is combinational from req; the controller samples it only in IDLE.
- FSM states:
  - IDLE:
    - gnt_id in 0..3 and req[gnt_id]=1 -> GRANT; latch owner_id=gnt_id, gnt=onehot(gnt_id), counter=0.
    - gnt_id==4 -> stay.
    - gnt_id in 5..7 -> stay, pulse illegal_id.
    - gnt_id in 0..3 with req[gnt_id]=0 (inconsistent arbiter) -> stay, no pulse.
  - GRANT:
    - gnt held, counter increments each cycle.
    - done[owner_id]=1 -> RELEASE. Done takes priority if it coincides with expiry: no timeout pulse.
    - Else counter==MAX_HOLD-1 -> RELEASE, timeout=1 for that one cycle.
    - done bits of non-owners are ignored.
  - RELEASE:
    - exactly one cycle; gnt=0, owner_id=4, pending[owner] cleared on entry;
    - -> IDLE unconditionally.
    - Guarantees the arbiter sees the updated req before the next sample.
- busy=1 in GRANT and RELEASE, 0 in IDLE.
- Latency:
  - req_pulse at edge E0 -> req high after E0;
  - IDLE samples at E1 -> gnt high after E1 (one cycle request-to-grant from an idle controller).
  - done at edge Ek -> gnt low after Ek.
  - Minimum grant-to-grant gap is one RELEASE cycle plus one IDLE cycle.
- Grant length:
  - gnt high for exactly MAX_HOLD cycles on timeout;
  - 1..MAX_HOLD cycles on done (done at the first GRANT cycle gives a 1-cycle grant).
- Priority follows the arbiter: the lowest pending index wins at each IDLE sample. The controller adds no fairness.
- gnt is always one-hot or zero and never changes owner without passing through RELEASE.

Test Plan:
- Reset then idle: rst pulse, no requests -> req=0000, gnt=0000, owner_id=4, busy=0 for 20 cycles.
- Single request: req_pulse=0100 at cycle 5, done[2] at cycle 9 -> req=0100 from cycle 6, gnt=0100 from cycle 7 through 9, RELEASE at cycle 10, req=0000 after.
- Contention: req_pulse=1011 at once, each owner asserts done on its 2nd grant cycle -> grant order 0,1,3 with gnt one-hot, one RELEASE+IDLE gap between grants, req=0000 at end.
- Timeout: MAX_HOLD=16, client 1 never asserts done -> gnt=0010 for exactly 16 cycles, timeout pulses once, req[1] cleared; done on the expiry cycle gives no timeout pulse.
- Re-request and stray done: owner 0 pulses req_pulse[0] during its grant and done[3] is asserted -> done[3] ignored; after RELEASE req[0] still 1 and client 0 is re-granted.
- Illegal and mid-op reset: force gnt_id=6 in IDLE -> illegal_id one pulse, no grant; assert rst during a grant -> gnt=0000, owner_id=4 in the same cycle, without waiting for a clock edge.
